// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUop codes and
// datapath mux selects. The ALU control unit decodes the same ALUOP_* values.
package mips_defs;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_BR   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multi-cycle main control FSM.
// mem_ready arrives already gated by the top when the handshake is disabled.
module mc_next_state
  import mips_defs::*;
#(
  parameter int STATE_W = 4,
  parameter logic [STATE_W-1:0] S_FETCH  = 'd0,
  parameter logic [STATE_W-1:0] S_DECODE = 'd1,
  parameter logic [STATE_W-1:0] S_MEMADR = 'd2,
  parameter logic [STATE_W-1:0] S_MEMRD  = 'd3,
  parameter logic [STATE_W-1:0] S_MEMWB  = 'd4,
  parameter logic [STATE_W-1:0] S_MEMWR  = 'd5,
  parameter logic [STATE_W-1:0] S_EXEC   = 'd6,
  parameter logic [STATE_W-1:0] S_ALUWB  = 'd7,
  parameter logic [STATE_W-1:0] S_BRANCH = 'd8,
  parameter logic [STATE_W-1:0] S_ADDIEX = 'd9,
  parameter logic [STATE_W-1:0] S_ADDIWB = 'd10,
  parameter logic [STATE_W-1:0] S_JUMP   = 'd11,
  parameter logic [STATE_W-1:0] S_HALT   = 'd12
) (
  input  logic [STATE_W-1:0] state,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] next
);

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(op))       next = S_MEMADR;
        else if (op == OP_R)     next = S_EXEC;
        else if (op == OP_BEQ)   next = S_BRANCH;
        else if (op == OP_ADDI)  next = S_ADDIEX;
        else if (op == OP_J)     next = S_JUMP;
        else                     next = S_HALT;
      end
      // op cannot legally change between DECODE and MEMADR; anything else traps.
      S_MEMADR: begin
        if (op == OP_LW)         next = S_MEMRD;
        else if (op == OP_SW)    next = S_MEMWR;
        else                     next = S_HALT;
      end
      S_MEMRD:  next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next = S_FETCH;
      S_MEMWR:  next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next = S_ALUWB;
      S_ALUWB:  next = S_FETCH;
      S_BRANCH: next = S_FETCH;
      S_ADDIEX: next = S_ADDIWB;
      S_ADDIWB: next = S_FETCH;
      S_JUMP:   next = S_FETCH;
      S_HALT:   next = S_HALT;
      default:  next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: state register plus Moore output
// decode. Handshake: a memory request (mem_read/mem_write) completes in the cycle mem_ready=1.
module multicycle_main_ctrl
  import mips_defs::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               halted,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(12);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next;
  logic               rdy;
  logic               unused_zero;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  // The beq decision is taken in the datapath from zero and pc_write_cond.
  assign unused_zero = zero;

  mc_next_state #(
    .STATE_W  (STATE_W),
    .S_FETCH  (S_FETCH),
    .S_DECODE (S_DECODE),
    .S_MEMADR (S_MEMADR),
    .S_MEMRD  (S_MEMRD),
    .S_MEMWB  (S_MEMWB),
    .S_MEMWR  (S_MEMWR),
    .S_EXEC   (S_EXEC),
    .S_ALUWB  (S_ALUWB),
    .S_BRANCH (S_BRANCH),
    .S_ADDIEX (S_ADDIEX),
    .S_ADDIWB (S_ADDIWB),
    .S_JUMP   (S_JUMP),
    .S_HALT   (S_HALT)
  ) u_next (
    .state     (state),
    .op        (op),
    .mem_ready (rdy),
    .next      (next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next;
  end

  assign state_o = rst ? S_FETCH : state;

  // rst masks every strobe in the same cycle so an aborted access issues nothing.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    halted        = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          ir_write  = rdy;
          pc_write  = rdy;
        end
        S_DECODE: alu_src_b = ALUB_BR;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        S_HALT:   halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Bench for multicycle_main_ctrl: instruction-level reference model feeding an expected
// queue, and a monitor comparing every control output once per cycle.
module tb_multicycle_main_ctrl;
  import mips_defs::*;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  multicycle_main_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .halted        (halted),
    .state_o       (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got hang, expected completion");
    $fatal(1, "timeout");
  end

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
                P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_HALT, P_RST} phase_t;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int zero_mode = -1;

  wire [W-1:0] act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, halted};

  // Reference: what each phase of an instruction drives onto the datapath.
  function automatic logic [W-1:0] model(input phase_t p, input logic rdy);
    logic pcw = 0, pcwc = 0, ad = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0;
    logic rw = 0, sa = 0, hlt = 0;
    logic [1:0] sb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (p)
      P_FETCH:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE: sb = 2'b11;
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin ad = 1; mrd = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin ad = 1; mwr = 1; end
      P_EXEC:   begin sa = 1; aop = 2'b10; end
      P_ALUWB:  begin rw = 1; rdst = 1; end
      P_BRANCH: begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      P_ADDIEX: begin sa = 1; sb = 2'b10; end
      P_ADDIWB: rw = 1;
      P_JUMP:   begin pcw = 1; psrc = 2'b10; end
      P_HALT:   hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, ad, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, psrc, hlt};
  endfunction

  // driver: one cycle of stimulus, expected response queued for the monitor
  task automatic step(input phase_t p, input logic rdy, input logic [5:0] iop);
    @(negedge clk);
    rst       = (p == P_RST);
    mem_ready = rdy;
    zero      = (zero_mode < 0) ? 1'($urandom) : zero_mode[0];
    op        = (p == P_DECODE || p == P_MEMADR) ? iop : 6'($urandom_range(0, 63));
    exp_q.push_back(model(p, rdy));
  endtask

  // Runs one instruction; abort_at >= 0 replaces that cycle with a reset.
  task automatic run_instr(input logic [5:0] iop, input int fetch_waits,
                           input int mem_waits, input int abort_at);
    phase_t seq[$];
    logic   rq[$];
    bit     legal = 1;
    for (int i = 0; i < fetch_waits; i++) begin seq.push_back(P_FETCH); rq.push_back(0); end
    seq.push_back(P_FETCH);  rq.push_back(1);
    seq.push_back(P_DECODE); rq.push_back(1'($urandom));
    case (iop)
      OP_LW, OP_SW: begin
        phase_t mp = (iop == OP_LW) ? P_MEMRD : P_MEMWR;
        seq.push_back(P_MEMADR); rq.push_back(1'($urandom));
        for (int i = 0; i < mem_waits; i++) begin seq.push_back(mp); rq.push_back(0); end
        seq.push_back(mp); rq.push_back(1);
        if (iop == OP_LW) begin seq.push_back(P_MEMWB); rq.push_back(1'($urandom)); end
      end
      OP_R: begin
        seq.push_back(P_EXEC);  rq.push_back(1'($urandom));
        seq.push_back(P_ALUWB); rq.push_back(1'($urandom));
      end
      OP_ADDI: begin
        seq.push_back(P_ADDIEX); rq.push_back(1'($urandom));
        seq.push_back(P_ADDIWB); rq.push_back(1'($urandom));
      end
      OP_BEQ: begin seq.push_back(P_BRANCH); rq.push_back(1'($urandom)); end
      OP_J:   begin seq.push_back(P_JUMP);   rq.push_back(1'($urandom)); end
      default: begin
        legal = 0;
        for (int i = 0; i < 12; i++) begin seq.push_back(P_HALT); rq.push_back(1'($urandom)); end
      end
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      if (k == abort_at) begin
        step(P_RST, 1'($urandom), 6'd0);
        return;
      end
      step(seq[k], rq[k], iop);
    end
    if (!legal) step(P_RST, 1'($urandom), 6'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_outputs cycle %0d: got %b expected %b (pcw,pcwc,iord,mrd,mwr,irw,rdst,m2r,rw,sa,sb,aop,psrc,hlt)",
                 cycle, act, e);
      end
    end
  end

  logic [5:0] ops[6];

  initial begin
    rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

    step(P_RST, 1'b0, 6'd0);
    step(P_RST, 1'b1, 6'd0);

    run_instr(OP_R, 0, 0, -1);                  // R-type, no waits
    run_instr(OP_LW, 0, 2, -1);                 // lw, 2 read wait cycles
    zero_mode = 1; run_instr(OP_BEQ, 0, 0, -1); // beq taken
    zero_mode = 0; run_instr(OP_BEQ, 0, 0, -1); // beq not taken
    zero_mode = -1;
    run_instr(OP_R, 3, 0, -1);                  // fetch stall
    run_instr(6'b111111, 0, 0, -1);             // illegal op traps, reset out
    run_instr(OP_SW, 0, 3, 4);                  // reset during a waiting write
    run_instr(OP_J, 0, 0, -1);
    run_instr(OP_ADDI, 1, 0, -1);
    run_instr(OP_SW, 0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] iop;
      int fw, mw, ab;
      iop = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(iop, fw, mw, ab);
    end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
